neighbour_count: RTL

- Counts the mines adjacent to a board cell that has just been revealed, and reports whether the cell itself holds a mine.
- Sits downstream of the mine placement/check stage. It takes the revealed cell index and reads the mine board one cell per cycle through a synchronous read port.
- Feeds the board redraw logic, which displays the number, and the game-state logic.

---
 rtl/neighbour_count.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/neighbour_count.sv
// neighbour_count: counts mines around a revealed cell by scanning its
// 3x3 neighbourhood through a synchronous one-bit board read port.
module neighbour_count #(
    parameter int MAX_DIM = 16,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] cell_x,
    input  logic [IDX_W-1:0] cell_y,
    input  logic [IDX_W-1:0] dim,
    output logic             mine_rd_en,
    output logic [IDX_W-1:0] mine_rd_x,
    output logic [IDX_W-1:0] mine_rd_y,
    input  logic             mine_rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       count,
    output logic             is_mine,
    output logic [IDX_W-1:0] cell_x_out,
    output logic [IDX_W-1:0] cell_y_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    localparam logic [IDX_W:0] OFF_M1 = '1;
    localparam logic [IDX_W:0] OFF_Z  = '0;
    localparam logic [IDX_W:0] OFF_P1 = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] DIM_MAX = (IDX_W+1)'(MAX_DIM);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_k;
    logic [3:0]       r_vk;
    logic             r_v;
    logic             r_err;
    logic             r_mine;
    logic [3:0]       r_count;
    logic [IDX_W-1:0] r_x;
    logic [IDX_W-1:0] r_y;
    logic [IDX_W-1:0] r_dim;
    logic [IDX_W:0]   w_dx;
    logic [IDX_W:0]   w_dy;
    logic [IDX_W:0]   w_nx;
    logic [IDX_W:0]   w_ny;
    logic             w_ok;
    logic             w_rd;

    assign w_ok = (cell_x < dim) && (cell_y < dim)
               && ({1'b0, dim} <= DIM_MAX);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && w_ok) w_next = SCAN;
            SCAN:    if (r_k == 4'd8) w_next = DRAIN;
            DRAIN:   w_next = REPORT;
            REPORT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_dx = OFF_Z;
        w_dy = OFF_Z;
        case (r_k)
            4'd0:    begin w_dx = OFF_Z;  w_dy = OFF_Z;  end
            4'd1:    begin w_dx = OFF_M1; w_dy = OFF_M1; end
            4'd2:    begin w_dx = OFF_Z;  w_dy = OFF_M1; end
            4'd3:    begin w_dx = OFF_P1; w_dy = OFF_M1; end
            4'd4:    begin w_dx = OFF_M1; w_dy = OFF_Z;  end
            4'd5:    begin w_dx = OFF_P1; w_dy = OFF_Z;  end
            4'd6:    begin w_dx = OFF_M1; w_dy = OFF_P1; end
            4'd7:    begin w_dx = OFF_Z;  w_dy = OFF_P1; end
            default: begin w_dx = OFF_P1; w_dy = OFF_P1; end
        endcase
    end

    // A -1 step from 0 wraps to all-ones, so one unsigned compare covers both edges.
    assign w_nx = {1'b0, r_x} + w_dx;
    assign w_ny = {1'b0, r_y} + w_dy;
    assign w_rd = (r_state == SCAN)
               && (w_nx < {1'b0, r_dim})
               && (w_ny < {1'b0, r_dim});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_vk    <= '0;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
            r_mine  <= 1'b0;
            r_count <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_dim   <= '0;
        end else begin
            r_err <= 1'b0;
            r_v   <= w_rd;
            r_vk  <= r_k;
            case (r_state)
                IDLE: begin
                    if (start && w_ok) begin
                        r_x     <= cell_x;
                        r_y     <= cell_y;
                        r_dim   <= dim;
                        r_k     <= '0;
                        r_count <= '0;
                        r_mine  <= 1'b0;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                SCAN:    r_k <= r_k + 4'd1;
                default: ;
            endcase
            if (r_v) begin
                if (r_vk == 4'd0)      r_mine  <= mine_rd_data;
                else if (mine_rd_data) r_count <= r_count + 4'd1;
            end
        end
    end

    assign mine_rd_en = w_rd;
    assign mine_rd_x  = w_rd ? w_nx[IDX_W-1:0] : '0;
    assign mine_rd_y  = w_rd ? w_ny[IDX_W-1:0] : '0;
    assign busy       = (r_state == SCAN) || (r_state == DRAIN);
    assign done       = (r_state == REPORT);
    assign err        = r_err;
    assign count      = r_count;
    assign is_mine    = r_mine;
    assign cell_x_out = r_x;
    assign cell_y_out = r_y;

endmodule
